// File: rtl/ab_stim_gen.sv
// Exhaustive 2-input stimulus generator: walks {a,b} through 00..11 for len vectors and
// counts DUT responses that disagree with a 4-entry truth table, LAT cycles later.
module ab_stim_gen #(
  parameter int unsigned LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [3:0] truth,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [7:0] vec_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [7:0]     len_q;
  logic [3:0]     truth_q;
  logic [2:0]     drain_q;
  logic [LAT-1:0] pv_q;
  logic [LAT-1:0] pe_q;
  logic           accept, last_vec, drain_end, mismatch;

  assign accept    = (state_q == StIdle) && start;
  assign last_vec  = (state_q == StRun) && (vec_cnt == len_q - 8'd1);
  assign drain_end = (state_q == StDrain) && (drain_q == 3'(LAT - 1));
  assign mismatch  = pv_q[LAT-1] && (dut_out != pe_q[LAT-1]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (len == 8'd0) ? StDone : StRun;
      StRun:   if (last_vec) state_d = StDrain;
      StDrain: if (drain_end) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // The vector index is the low bits of vec_cnt, which restarts at 0 each run.
    {a, b} = (state_q == StRun) ? vec_cnt[1:0] : 2'b10;
    busy   = (state_q == StRun) || (state_q == StDrain);
    done   = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= 8'd0;
      truth_q <= 4'd0;
      vec_cnt <= 8'd0;
      err_cnt <= 8'd0;
      drain_q <= 3'd0;
      pv_q    <= '0;
      pe_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q   <= len;
        truth_q <= truth;
        vec_cnt <= 8'd0;
        err_cnt <= 8'd0;
      end else begin
        if (state_q == StRun) vec_cnt <= vec_cnt + 8'd1;
        if (mismatch && (err_cnt != 8'hff)) err_cnt <= err_cnt + 8'd1;
      end
      drain_q <= (state_q == StDrain) ? drain_q + 3'd1 : 3'd0;
      // Expectation pipeline: stage LAT-1 lines up with the DUT response.
      pv_q[0] <= (state_q == StRun);
      pe_q[0] <= truth_q[vec_cnt[1:0]];
      for (int unsigned i = 1; i < LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

endmodule
